// File: rtl/ex_div_unit_pkg.sv
// Shared types for the EX-stage iterative divider: FSM state encoding and an abs helper.
package ex_div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    // Magnitude of v; the most negative value maps to itself, which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v, input logic sgn);
        return (sgn && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU inside EX; stalls IF/ID/EX while working.
// Optional build macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             div_annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             stallreq_div
);

    div_state_e           state_q, state_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     out_quo_q, out_quo_d;
    logic [WIDTH-1:0]     out_rem_q, out_rem_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;

    logic             accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   r_sh, r_sub;
    logic             ge;
    logic [WIDTH-1:0] res_quo, res_rem;

    assign accept  = (state_q == DIV_IDLE) && div_start && !div_annul;
    assign abs_a   = div_abs(dividend, div_signed);
    assign abs_b   = div_abs(divisor, div_signed);
    // 33-bit partial remainder so the shifted-in bit never overflows the compare.
    assign r_sh    = {rem_q, quo_q[WIDTH-1]};
    assign r_sub   = r_sh - {1'b0, dvs_q};
    assign ge      = (r_sh >= {1'b0, dvs_q});
    assign res_quo = neg_quo_q ? -quo_q : quo_q;
    assign res_rem = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        out_quo_d = out_quo_q;
        out_rem_d = out_rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    neg_quo_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = div_signed & dividend[WIDTH-1];
                    dvs_d     = abs_b;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        state_d   = DIV_ZERO;
                        quo_d     = '1;
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        state_d   = DIV_END;
                        quo_d     = '0;
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
`endif
                    else begin
                        state_d = DIV_BUSY;
                        quo_d   = abs_a;
                        rem_d   = '0;
                    end
                end
            end
            DIV_ZERO: state_d = DIV_END;
            DIV_BUSY: begin
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(WIDTH-1)) state_d = DIV_END;
            end
            DIV_END: begin
                state_d   = DIV_IDLE;
                out_quo_d = res_quo;
                out_rem_d = res_rem;
            end
            default: state_d = DIV_IDLE;
        endcase
        // A flush wins over everything and leaves the visible results untouched.
        if (div_annul) begin
            state_d   = DIV_IDLE;
            out_quo_d = out_quo_q;
            out_rem_d = out_rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            out_quo_q <= '0;
            out_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            out_quo_q <= out_quo_d;
            out_rem_q <= out_rem_d;
        end
    end

    // Results are visible combinationally in END so EX can pack them in the ready cycle.
    assign div_ready    = (state_q == DIV_END) && !div_annul;
    assign quotient     = div_ready ? res_quo : out_quo_q;
    assign remainder    = div_ready ? res_rem : out_rem_q;
    assign stallreq_div = accept || (state_q == DIV_ZERO) || (state_q == DIV_BUSY);

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: randomized DIV/DIVU against an arithmetic reference model.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic        div_annul = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        stallreq_div;

    ex_div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_annul   (div_annul),
        .dividend    (dividend),
        .divisor     (divisor),
        .div_ready   (div_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .stallreq_div(stallreq_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint mag(input logic s, input logic [31:0] v);
        longint x;
        x = s ? longint'($signed(v)) : longint'(v);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: plain integer division with MIPS DIV/DIVU corner cases.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        int sa, sd;
        lat = 33;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 2;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 0;
            end else begin
                sa = $signed(a); sd = $signed(b);
                q = 32'(sa / sd); r = 32'(sa % sd);
            end
        end else begin
            q = a / b; r = a % b;
        end
`ifdef DIV_EARLY_OUT_EN
        if (b != 0 && mag(s, a) < mag(s, b)) lat = 1;
`endif
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && div_ready) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_ready: got ready=1 expected ready=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                chk("stall_at_ready", {31'b0, stallreq_div}, 32'd0);
            end
        end
    end

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int lat, guard, st;
        model(s, a, b, q, r, lat);
        @(negedge clk);
        div_start = 1'b1; div_signed = s; dividend = a; divisor = b;
        #1;
        chk("stall_accept", {31'b0, stallreq_div}, 32'd1);
        sb.push_back('{q: q, r: r, lat: lat, acc: cyc});
        guard = 0; st = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            #3;
            if (sb.size() != 0 && stallreq_div) st++;
            guard++;
        end
        if (sb.size() != 0) begin
            checks++; fails++;
            $display("FAIL ready_timeout: got no ready expected ready within %0d cycles", lat);
            sb.delete();
        end else begin
            chk("stall_cycles", 32'(st), 32'(lat - 1));
        end
        div_start = 1'b0;
        last_q = q; last_r = r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [31:0] a, b;
        int          mode;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, div_ready}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_stall", {31'b0, stallreq_div}, 32'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'd5, 32'd0);
        run_op(1'b1, 32'hFFFF_FFF3, 32'd0);
        run_op(1'b0, 32'd3, 32'd8);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd8);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);

        // Flush in the middle of BUSY: no ready, results hold.
        @(negedge clk);
        div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        repeat (10) @(negedge clk);
        div_annul = 1'b1; div_start = 1'b0;
        @(negedge clk);
        #1;
        chk("annul_stall", {31'b0, stallreq_div}, 32'd0);
        chk("annul_hold_q", quotient, last_q);
        chk("annul_hold_r", remainder, last_r);
        div_annul = 1'b0;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3);

        // Reset in the middle of BUSY.
        @(negedge clk);
        div_start = 1'b1; div_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
        repeat (5) @(negedge clk);
        rst = 1'b1; div_start = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_ready", {31'b0, div_ready}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_stall", {31'b0, stallreq_div}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            case (mode)
                1: b = $urandom_range(1, 15);
                2: b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF;
                3: begin b = $urandom_range(16, 4096); a = $urandom_range(0, 15); end
                default: ;
            endcase
            run_op(s, a, b);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
